// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int unsigned WORD = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [WORD-1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [WORD-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: byte/half/word load/store with lane
// selection, sign/zero extension and misalignment/range error reporting.
module dmem_responder #(
  parameter int unsigned WORD        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = WORD - 2;
  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic            write;
    logic [WORD-1:0] addr;
    logic [WORD-1:0] wdata;
    logic [1:0]      size;
    logic            uns;
  } req_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  req_t             req_q, cur;
  logic             accept;
  logic             commit;
  logic             err_c;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [WORD-1:0]  rd_word;
  logic [WORD-1:0]  wr_word;
  logic [WORD-1:0]  load_data;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;

  logic [WORD-1:0] mem [DEPTH_WORDS];

  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // Transaction being worked on: the live bus in IDLE (for LATENCY=1 commits), else the latched copy.
  always_comb begin
    cur = req_q;
    if (state == IDLE) begin
      cur.write = bus.req_write;
      cur.addr  = bus.req_addr;
      cur.wdata = bus.req_wdata;
      cur.size  = bus.req_size;
      cur.uns   = bus.req_unsigned;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, latency countdown and commit strobe (edge entering RESP).
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY <= 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT_M1;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) commit = 1'b0;
  end

  // Access checks, load lane extraction and store read-modify-write merge.
  always_comb begin
    idx   = cur.addr[WORD-1:2];
    lane  = cur.addr[1:0];
    err_c = (idx >= IDX_W'(DEPTH_WORDS));
    unique case (cur.size)
      2'b00:   ;
      2'b01:   if (cur.addr[0]) err_c = 1'b1;
      2'b10:   if (cur.addr[1:0] != 2'b00) err_c = 1'b1;
      default: err_c = 1'b1;
    endcase

    rd_word = mem[cur.addr[AW+1:2]];
    byte_v  = rd_word[{lane, 3'b000} +: 8];
    half_v  = rd_word[{cur.addr[1], 4'b0000} +: 16];

    unique case (cur.size)
      2'b00:   load_data = cur.uns ? {{(WORD-8){1'b0}}, byte_v}
                                   : {{(WORD-8){byte_v[7]}}, byte_v};
      2'b01:   load_data = cur.uns ? {{(WORD-16){1'b0}}, half_v}
                                   : {{(WORD-16){half_v[15]}}, half_v};
      default: load_data = rd_word;
    endcase

    wr_word = rd_word;
    unique case (cur.size)
      2'b00:   wr_word[{lane, 3'b000} +: 8]         = cur.wdata[7:0];
      2'b01:   wr_word[{cur.addr[1], 4'b0000} +: 16] = cur.wdata[15:0];
      default: wr_word                              = cur.wdata;
    endcase
  end

  // Storage array: stores land only on an error-free commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && cur.write && !err_c) mem[cur.addr[AW+1:2]] <= wr_word;
  end

  // Latched request, countdown and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q         <= '0;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      cnt <= cnt_next;
      if (accept) req_q <= cur;
      if (commit) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= err_c;
        bus.rsp_rdata <= (err_c || cur.write) ? '0 : load_data;
      end else if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed + scoreboard bench for dmem_responder with a byte-addressed reference model.
module tb_dmem_responder;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 1024;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_responder_if #(.WORD(32)) bus ();

  dmem_responder #(
    .WORD(32),
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t sbq[$];
  logic [7:0] mdl [int unsigned];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : 8'h00;
  endfunction

  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
           || ((a >> 2) >= 32'(DEPTH));
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] v;
    v = {mb(a + 3), mb(a + 2), mb(a + 1), mb(a)};
    if (sz == 2'b00)      v = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
    else if (sz == 2'b01) v = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mdl[a + 32'(i)] = wd[8*i +: 8];
  endtask

  // One full transaction; entered and left just after a rising edge.
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic uns, input int hold,
                     input bit use_lit, input logic [31:0] lit_rd, input logic lit_err,
                     input string tag);
    exp_t e;
    int   n;
    bit   ok;
    e.err   = m_err(sz, a);
    e.rdata = (e.err || wr) ? 32'h0 : m_load(sz, uns, a);
    if (use_lit) begin
      e.rdata = lit_rd;
      e.err   = lit_err;
    end
    sbq.push_back(e);
    if (wr && !m_err(sz, a)) m_store(sz, a, wd);

    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " accept"}, 32'(ok), 32'd1);
    if (!ok) begin
      bus.req_valid = 1'b0;
      void'(sbq.pop_front());
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    n  = 0;
    ok = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        n  = i;
        ok = 1'b1;
        break;
      end
    end
    check({tag, " latency"}, 32'(n), 32'(LATENCY));
    e = sbq.pop_front();
    if (!ok) return;
    check({tag, " rdata"}, bus.rsp_rdata, e.rdata);
    check({tag, " err"}, 32'(bus.rsp_err), 32'(e.err));

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, " hold rdata"}, bus.rsp_rdata, e.rdata);
      check({tag, " hold req_ready"}, 32'(bus.req_ready), 32'd0);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, " post valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " post req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, " post rdata"}, bus.rsp_rdata, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(bus.req_ready), 32'd0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Known contents for the low 128 bytes.
    for (int w = 0; w < 32; w++)
      txn(1'b1, 32'(4 * w), 32'h0, 2'b10, 1'b0, 0, 1'b0, 32'h0, 1'b0, "prefill");

    txn(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b0, "st_w 10");
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'hDEADBEEF, 1'b0, "ld_w 10");

    txn(1'b1, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b0, "clr_w 10");
    txn(1'b1, 32'h13, 32'hAAAAAA80, 2'b00, 1'b0, 0, 1'b1, 32'h0, 1'b0, "st_b 13");
    txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, 1'b1, 32'hFFFFFF80, 1'b0, "ld_bs 13");
    txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, 1'b1, 32'h00000080, 1'b0, "ld_bu 13");
    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'h80000000, 1'b0, "ld_w 10b");

    txn(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b0, "st_w 20");
    txn(1'b1, 32'h22, 32'h5555BEEF, 2'b01, 1'b0, 0, 1'b1, 32'h0, 1'b0, "st_h 22");
    txn(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 0, 1'b1, 32'hFFFFBEEF, 1'b0, "ld_hs 22");
    txn(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 0, 1'b1, 32'h0000BEEF, 1'b0, "ld_hu 22");
    txn(1'b0, 32'h20, 32'h0, 2'b00, 1'b1, 0, 1'b1, 32'h00000044, 1'b0, "ld_bu 20");
    txn(1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 0, 1'b1, 32'h00000033, 1'b0, "ld_bu 21");

    txn(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b1, "mis ld_w 11");
    txn(1'b1, 32'h21, 32'hAAAA, 2'b01, 1'b0, 0, 1'b1, 32'h0, 1'b1, "mis st_h 21");
    txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'hBEEF3344, 1'b0, "ld_w 20 kept");
    txn(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, 1'b1, 32'h0, 1'b1, "size 11");
    txn(1'b0, 32'(4 * DEPTH), 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b1, "oor ld");
    txn(1'b1, 32'(4 * DEPTH), 32'h1, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b1, "oor st");
    txn(1'b0, 32'(4 * DEPTH - 4), 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b0, "last word");

    txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, 1'b1, 32'h80000000, 1'b0, "backpressure");

    // A store interrupted by reset while waiting must not reach memory.
    txn(1'b1, 32'h40, 32'hCAFEF00D, 2'b10, 1'b0, 0, 1'b1, 32'h0, 1'b0, "st_w 40");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h40;
    bus.req_wdata = 32'h12345678;
    bus.req_size  = 2'b10;
    @(negedge clk);
    check("rst accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("after rst req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("after rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    txn(1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'hCAFEF00D, 1'b0, "ld_w 40 kept");

    // Random mix over the low region, checked against the byte model.
    for (int k = 0; k < 24; k++) begin
      logic [31:0] ra;
      logic [1:0]  rs;
      logic        rw, ru;
      ra = 32'($urandom_range(0, 127));
      rs = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      txn(rw, ra, $urandom, rs, ru, 0, 1'b0, 32'h0, 1'b0, "rand");
    end

    check("scoreboard empty", 32'(sbq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
